// File: rtl/calc_pkg.sv
// Shared opcode map and FSM state type for the sequential calculator.
// Only seq_calc's optional multiply (macro CALC_MUL_EN) depends on OP_MUL.
package calc_pkg;

  localparam logic [2:0] OP_ADD_AB = 3'b000;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_ABS_B  = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_ADD_BA = 3'b100;
  localparam logic [2:0] OP_SUB_BA = 3'b101;
  localparam logic [2:0] OP_ABS_A  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } calc_state_t;

endpackage

// File: rtl/calc_addsub.sv
// W-bit two's complement adder with carry-in and signed overflow detect.
// Subtraction and negation are formed by the caller inverting an operand and setting c0.
module calc_addsub #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c0,
  output logic [W-1:0] s,
  output logic         ovf
);

  assign s   = x + y + {{(W-1){1'b0}}, c0};
  assign ovf = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);

endmodule

// File: rtl/seq_calc.sv
// Registered W-bit calculator with valid/ready handshakes and sticky overflow.
// Define CALC_MUL_EN to turn opcode 011 into a W-cycle signed shift-add multiply.
module seq_calc
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output logic         ovf,
  output logic         ovf_sticky,
  input  logic         clr_sticky,
  output logic         busy
);

  calc_state_t  state_q, state_d;
  logic [W-1:0] r_q, r_d;
  logic         ovf_q, ovf_d;
  logic         sticky_q, sticky_d;
  logic         load;

  logic [W-1:0] add_x, add_y, add_s, abs_src;
  logic         add_c0, add_ovf;

  logic         is_mul, mul_last, mul_neg, mul_fits;
  logic [W-1:0] mul_lo;

  calc_addsub #(.W(W)) u_addsub (
    .x  (add_x),
    .y  (add_y),
    .c0 (add_c0),
    .s  (add_s),
    .ovf(add_ovf)
  );

`ifdef CALC_MUL_EN
  localparam int CW = $clog2(W);

  logic [W-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic [W:0]     partial;
  logic [W:0]     prod_hi;

  assign is_mul   = (op == OP_MUL);
  assign mul_last = (cnt_q == CW'(W - 1));
  assign mul_neg  = neg_q;
  assign mul_lo   = acc_d[W-1:0];
  assign prod_hi  = acc_d[2*W-1:W-1];
  // A negative product may reach exactly -2^(W-1), one step beyond the positive limit.
  assign mul_fits = (prod_hi == '0) ||
                    (neg_q && (prod_hi == (W+1)'(1)) && (acc_d[W-2:0] == '0));

  always_comb begin
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    partial = {1'b0, acc_q[2*W-1:W]} + (mb_q[0] ? {1'b0, ma_q} : '0);
    if (state_q == IDLE && in_valid && is_mul) begin
      ma_d  = a[W-1] ? (~a + 1'b1) : a;
      mb_d  = b[W-1] ? (~b + 1'b1) : b;
      acc_d = '0;
      cnt_d = '0;
      neg_d = a[W-1] ^ b[W-1];
    end else if (state_q == MUL) begin
      acc_d = {partial, acc_q[W-1:1]};
      mb_d  = mb_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_q  <= '0;
      mb_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else begin
      ma_q  <= ma_d;
      mb_q  <= mb_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_last = 1'b0;
  assign mul_neg  = 1'b0;
  assign mul_lo   = '0;
  assign mul_fits = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    add_x   = a;
    add_y   = b;
    add_c0  = 1'b0;
    abs_src = op[2] ? a : b;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_mul) begin
            state_d = MUL;
          end else begin
            case (op)
              OP_ADD_AB: begin add_x = a; add_y = b; end
              OP_SUB_AB: begin add_x = a; add_y = ~b; add_c0 = 1'b1; end
              OP_ADD_BA: begin add_x = b; add_y = a; end
              OP_SUB_BA: begin add_x = b; add_y = ~a; add_c0 = 1'b1; end
              default: begin
                add_x  = abs_src[W-1] ? ~abs_src : abs_src;
                add_y  = '0;
                add_c0 = abs_src[W-1];
              end
            endcase
            r_d     = add_s;
            ovf_d   = add_ovf;
            load    = 1'b1;
            state_d = DONE;
          end
        end
      end
      MUL: begin
        // Final iteration: negate the magnitude through the shared adder if needed.
        add_x  = mul_neg ? ~mul_lo : mul_lo;
        add_y  = '0;
        add_c0 = mul_neg;
        if (mul_last) begin
          r_d     = add_s;
          ovf_d   = ~mul_fits;
          load    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sticky_d = sticky_q;
    if (load && ovf_d)   sticky_d = 1'b1;
    else if (clr_sticky) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign r          = r_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_seq_calc.sv
// Self-checking bench for seq_calc: directed vector table, hand sequences for
// handshake/reset corners, and randomized commands against an arithmetic model.
module tb_seq_calc;

  localparam int W = 16;
  localparam int P = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] r;
  logic         ovf;
  logic         ovf_sticky;
  logic         clr_sticky = 1'b0;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #(P/2) clk = ~clk;

  seq_calc #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .ovf       (ovf),
    .ovf_sticky(ovf_sticky),
    .clr_sticky(clr_sticky),
    .busy      (busy)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] er;
    logic         eo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then range test and wrap to W bits.
  function automatic void model(input logic [2:0] op_i, input logic [W-1:0] a_i,
                                input logic [W-1:0] b_i, output logic [W-1:0] er,
                                output logic eo);
    longint sa  = longint'($signed(a_i));
    longint sb  = longint'($signed(b_i));
    longint lim = longint'(1) <<< (W - 1);
    longint v;
    case (op_i)
      3'd0: v = sa + sb;
      3'd1: v = sa - sb;
      3'd4: v = sb + sa;
      3'd5: v = sb - sa;
`ifdef CALC_MUL_EN
      3'd3: v = sa * sb;
`else
      3'd3: v = (sb < 0) ? -sb : sb;
`endif
      3'd2: v = (sb < 0) ? -sb : sb;
      default: v = (sa < 0) ? -sa : sa;
    endcase
    eo = (v >= lim) || (v < -lim);
    er = v[W-1:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] op_i);
`ifdef CALC_MUL_EN
    if (op_i == 3'd3) return W + 1;
`endif
    return 1;
  endfunction

  // Called just after a falling edge; returns just after a falling edge in IDLE.
  task automatic run_cmd(input logic [2:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input int hold, output logic [W-1:0] r_o, output logic ovf_o,
                         output logic st_o, output int lat_o, output time acc_t);
    int n;
    bit stable;
    op = op_i; a = a_i; b = b_i; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    acc_t = $time;
    // Keep in_valid high with garbage: must not be taken while busy or in DONE.
    @(negedge clk);
    op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    lat_o = 1;
    while (!out_valid && lat_o < 3 * W) begin @(negedge clk); lat_o++; end
    r_o = r; ovf_o = ovf; st_o = ovf_sticky;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (r !== r_o || ovf !== ovf_o || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #(50000 * P);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rr, er;
    logic         ro, so, eo, sticky_exp;
    int           lat;
    time          t_acc, t_prev;
    bit           stale;

    vecs[0]  = '{3'b000, W'(32767),  W'(1),   W'(-32768), 1'b1};
    vecs[1]  = '{3'b101, W'(1000),   W'(250), W'(-750),   1'b0};
    vecs[2]  = '{3'b110, W'(-32768), W'(9),   W'(-32768), 1'b1};
    vecs[3]  = '{3'b010, W'(77),     W'(-5),  W'(5),      1'b0};
    vecs[4]  = '{3'b000, W'(3),      W'(4),   W'(7),      1'b0};
    vecs[5]  = '{3'b001, W'(3),      W'(4),   W'(-1),     1'b0};
    vecs[6]  = '{3'b001, W'(-32768), W'(1),   W'(32767),  1'b1};
    vecs[7]  = '{3'b100, W'(-1),     W'(-1),  W'(-2),     1'b0};
    vecs[8]  = '{3'b111, W'(-7),     W'(100), W'(7),      1'b0};
`ifdef CALC_MUL_EN
    vecs[9]  = '{3'b011, W'(-300),   W'(200), W'(5536),   1'b1};
    vecs[10] = '{3'b011, W'(-12),    W'(11),  W'(-132),   1'b0};
`else
    vecs[9]  = '{3'b011, W'(-300),   W'(200), W'(200),    1'b0};
    vecs[10] = '{3'b011, W'(-12),    W'(-11), W'(11),     1'b0};
`endif
    vecs[11] = '{3'b101, W'(-32768), W'(1),   W'(-32767), 1'b1};

    #1;
    check("reset_vals", {r, ovf, out_valid, ovf_sticky, in_ready, busy}, {W'(0), 5'b00010});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sticky_exp = 1'b0;
    t_prev = 0;

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, (i == 1) ? 5 : 0, rr, ro, so, lat, t_acc);
      sticky_exp |= vecs[i].eo;
      $display("[TB] vec %0d op=%b a=%0d b=%0d -> r=%0d ovf=%0b lat=%0d", i, vecs[i].op,
               $signed(vecs[i].a), $signed(vecs[i].b), $signed(rr), ro, lat);
      check($sformatf("vec%0d_r", i), rr, vecs[i].er);
      check($sformatf("vec%0d_ovf", i), ro, vecs[i].eo);
      check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].op));
      check($sformatf("vec%0d_sticky", i), so, sticky_exp);
      if (i == 5) check("b2b_gap_ok", (t_acc - t_prev) >= 2 * P, 1);
      t_prev = t_acc;
      if (i == 0) begin
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        sticky_exp = 1'b0;
        check("sticky_clear", ovf_sticky, 0);
      end
    end

    // Clear and set on the same edge: set must win.
    clr_sticky = 1'b1;
    op = 3'b000; a = W'(32767); b = W'(1); in_valid = 1'b1;
    @(posedge clk); #1;
    check("sticky_set_wins", ovf_sticky, 1);
    @(negedge clk);
    in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("[TB] sticky set/clear collision done");

    // in_valid and out_ready both held high: accepts only every other cycle.
    op = 3'b000; a = W'(1); b = W'(2); in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("alt_ready%0d", k), {in_ready, out_valid}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k % 2 == 1) check($sformatf("alt_r%0d", k), r, W'(3));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    $display("[TB] streaming handshake sequence done");

    // Reset in the middle of an operation discards it entirely.
`ifdef CALC_MUL_EN
    op = 3'b011; a = W'(-300); b = W'(200);
`else
    op = 3'b000; a = W'(32767); b = W'(5);
`endif
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_vals", {r, ovf, out_valid, ovf_sticky, in_ready, busy}, {W'(0), 5'b00010});
    @(negedge clk);
    rst = 1'b0;
    sticky_exp = 1'b0;
    stale = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    check("no_stale_result", stale, 0);
    run_cmd(3'b000, W'(10), W'(20), 0, rr, ro, so, lat, t_acc);
    $display("[TB] post-reset cmd r=%0d ovf=%0b", $signed(rr), ro);
    check("post_rst_r", rr, W'(30));
    check("post_rst_ovf", ro, 0);

    // Randomized commands against the arithmetic model.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 1) ? W'(-32768) : W'(32767);
      if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 1) ? W'(-32768) : W'(-1);
      model(rop, ra, rb, er, eo);
      run_cmd(rop, ra, rb, $urandom_range(0, 3), rr, ro, so, lat, t_acc);
      sticky_exp |= eo;
      $display("[TB] rnd %0d op=%b a=%0d b=%0d -> r=%0d ovf=%0b exp r=%0d ovf=%0b", n, rop,
               $signed(ra), $signed(rb), $signed(rr), ro, $signed(er), eo);
      check("rnd_r", rr, er);
      check("rnd_ovf", ro, eo);
      check("rnd_lat", lat, exp_lat(rop));
      check("rnd_sticky", so, sticky_exp);
      if ($urandom_range(0, 7) == 0) begin
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        sticky_exp = 1'b0;
        check("rnd_sticky_clr", ovf_sticky, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_calc.md
Name: seq_calc

Overview:
- Parametrised, registered successor to the 4-bit combinational calculator.
- Same opcode map (add, subtract in either order, absolute value) at width W, with a valid/ready handshake on both sides.
- Registered result plus per-result and sticky overflow; optional multi-cycle signed multiply.
- Sits between the operand/opcode source and the result sink in the calculator datapath.

Parameters:
- W, 16, operand/result width in bits (two's complement, W >= 4).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept a command
- op  input  3  opcode (see Behaviour)
- a  input  W  signed operand A
- b  input  W  signed operand B
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- r  output  W  signed result
- ovf  output  1  overflow flag for the current r
- ovf_sticky  output  1  OR of every ovf delivered since reset/clear
- clr_sticky  input  1  synchronous clear of ovf_sticky
- busy  output  1  high in any state except IDLE

Behaviour:
- Opcodes:
  - 000 A+B; 001 A-B; 010 abs(B); 011 abs(B) (multiply when CALC_MUL_EN).
  - 100 B+A; 101 B-A; 110 abs(A); 111 abs(A).
- FSM states IDLE, MUL, DONE; reset state IDLE.
- Reset values: r=0, ovf=0, out_valid=0, ovf_sticky=0, in_ready=1, busy=0.
- in_ready = (state==IDLE); a command is accepted on a clock edge where in_valid & in_ready.
- Accept of an add/sub/abs op: result and ovf registered on the same edge, state -> DONE. out_valid rises 1 cycle after the accept edge.
- Accept of a multiply op (CALC_MUL_EN only): state -> MUL for exactly W cycles, then DONE. out_valid rises W+1 cycles after the accept edge.
- DONE:
  - out_valid=1; r and ovf held stable until out_ready.
  - On the edge with out_ready: state -> IDLE, out_valid -> 0. r keeps its last value.
  - Throughput is 1 command per 2 cycles minimum. No command is accepted while in DONE, even if out_ready is high in the same cycle.
- Add/sub:
  - W-bit two's complement; subtraction = A + ~B + 1 via a single adder with carry-in.
  - ovf = operands (after inversion) share a sign and the result sign differs.
  - r = wrapped W-bit sum.
- abs:
  - Non-negative input passes through.
  - Negative input is inverted plus 1 through the same adder.
  - abs(-2^(W-1)) gives r = -2^(W-1), ovf=1.
- ovf_sticky:
  - Set on the edge where a result with ovf=1 is registered.
  - clr_sticky clears it. When set and clear coincide on the same edge, set wins.
- in_valid while busy: ignored; source must hold the command.
- out_ready while not DONE: ignored.
- rst asserted mid-MUL or mid-DONE: immediate return to reset values. The pending result is discarded and never presented.
- op, a, b are sampled only at accept; later changes do not affect an in-flight operation.

Optional Feature:
- Macro CALC_MUL_EN.
- Defined: opcode 011 = signed A*B.
  - Shift-add over W cycles on a 2W-bit accumulator, using magnitudes and a final sign fix.
  - r = low W bits of the product.
  - ovf = 1 when the product is outside the W-bit signed range.
- Undefined: 011 behaves as abs(B), state MUL is unreachable, and no multiply logic is synthesised.

Decomposition:
- Package calc_pkg:
  - Opcode localparams: OP_ADD_AB, OP_SUB_AB, OP_ABS_B, OP_MUL, OP_ADD_BA, OP_SUB_BA, OP_ABS_A.
  - State enum calc_state_t {IDLE, MUL, DONE}.
- Sub-module calc_addsub #(W):
  - Combinational W-bit adder/subtractor with inputs x, y, c0 and outputs s, ovf.
  - Shared by add, sub and abs, and used for the multiply sign fix.

Test Plan:
- W=4, op=000, a=7, b=1 -> out_valid one cycle after accept, r=-8, ovf=1, ovf_sticky=1. Then clr_sticky -> ovf_sticky=0.
- W=16, op=101, a=1000, b=250 -> r=-750, ovf=0. Hold out_ready=0 for 5 cycles: r stable, in_ready=0 throughout.
- W=16, op=110, a=-32768 -> r=-32768, ovf=1. Then op=010, b=-5 -> r=5, ovf=0.
- W=16, back-to-back in_valid with out_ready=1: op=000 (3,4), then op=001 (3,4) -> r=7 then r=-1, and the second accept occurs no earlier than 2 cycles after the first.
- CALC_MUL_EN, W=16, op=011, a=-300, b=200 -> out_valid after 17 cycles, r=-60000 wrapped = 5536, ovf=1. With a=-12, b=11 -> r=-132, ovf=0.
- rst pulse during MUL (cycle 5) -> out_valid=0, r=0, in_ready=1 immediately. The next command completes normally with no stale result.
